timer_counter: RTL and testbench

Time-base and mm:ss counter driven by the timer control state machine. It converts the control strobes (enableCounter, forward, resetTimer) and the set-mode demands (segDemand, minDemand) into a BCD minutes:seconds value for the VGA digit renderer. It also raises a terminal flag back to the control logic when a down-count reaches 00:00. It sits between the button/FSM layer and the VGA character generator, on the single system clock.

---
 rtl/timer_counter.sv | 190 +++++++++++++++++++
 tb/tb_timer_counter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Purpose : one-second time base plus BCD mm:ss counter (up, down, set mode) with a sticky time-up flag.
// Latency : digits change on the tick edge; set-mode demands reach the digits on the 2nd clk edge.
// Backpressure: none; strobe driven, outputs are registered levels plus a one-cycle tick pulse.
//
// Ports:
//   clk, rst_n                     system clock, async active-low reset
//   enableCounter                  1 = run (prescaler counts), 0 = stopped / set mode
//   forward                        1 = count up, 0 = count down (sampled on each tick)
//   resetTimer                     synchronous clear of digits, prescaler and timeUp
//   segDemand, minDemand           set-mode requests, act on their rising edges
//   secUnits/secTens/minUnits/minTens  BCD mm:ss for the digit renderer
//   tick                           one-cycle pulse per second of enabled time
//   timeUp                         sticky flag, raised when a down-count sits at 00:00
module timer_counter #(
    parameter int TICK_DIV = 100_000_000,
    parameter int DIV_W    = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enableCounter,
    input  logic       forward,
    input  logic       resetTimer,
    input  logic       segDemand,
    input  logic       minDemand,
    output logic [3:0] secUnits,
    output logic [3:0] secTens,
    output logic [3:0] minUnits,
    output logic [3:0] minTens,
    output logic       tick,
    output logic       timeUp
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             wrap;

    // One registered copy of each demand for edge detection, plus a registered
    // edge pulse; the pulse register is what gives the two-edge set latency.
    logic seg_q, min_q;
    logic seg_p, min_p;

    logic [3:0] up_su, up_st, up_mu, up_mt;
    logic [3:0] dn_su, dn_st, dn_mu, dn_mt;
    logic [3:0] set_su, set_st, set_mu, set_mt;
    logic       is_zero, dn_zero, set_nz;

    assign wrap    = (div == DIV_LAST);
    assign is_zero = (secUnits == 4'd0) && (secTens == 4'd0) &&
                     (minUnits == 4'd0) && (minTens == 4'd0);
    assign dn_zero = (dn_su == 4'd0) && (dn_st == 4'd0) &&
                     (dn_mu == 4'd0) && (dn_mt == 4'd0);
    assign set_nz  = (set_su != 4'd0) || (set_st != 4'd0) ||
                     (set_mu != 4'd0) || (set_mt != 4'd0);

    // BCD increment with full carry chain; 59:59 rolls to 00:00.
    always_comb begin
        up_su = secUnits + 4'd1;
        up_st = secTens;
        up_mu = minUnits;
        up_mt = minTens;
        if (secUnits == 4'd9) begin
            up_su = 4'd0;
            up_st = secTens + 4'd1;
            if (secTens == 4'd5) begin
                up_st = 4'd0;
                up_mu = minUnits + 4'd1;
                if (minUnits == 4'd9) begin
                    up_mu = 4'd0;
                    up_mt = (minTens == 4'd5) ? 4'd0 : minTens + 4'd1;
                end
            end
        end
    end

    // BCD decrement with full borrow chain; only used when the count is nonzero.
    always_comb begin
        dn_su = secUnits - 4'd1;
        dn_st = secTens;
        dn_mu = minUnits;
        dn_mt = minTens;
        if (secUnits == 4'd0) begin
            dn_su = 4'd9;
            dn_st = secTens - 4'd1;
            if (secTens == 4'd0) begin
                dn_st = 4'd5;
                dn_mu = minUnits - 4'd1;
                if (minUnits == 4'd0) begin
                    dn_mu = 4'd9;
                    dn_mt = (minTens == 4'd0) ? 4'd5 : minTens - 4'd1;
                end
            end
        end
    end

    // Set mode: seconds and minutes each wrap 59 -> 00 independently, no carry.
    always_comb begin
        set_su = secUnits;
        set_st = secTens;
        set_mu = minUnits;
        set_mt = minTens;
        if (seg_p) begin
            if (secUnits == 4'd9) begin
                set_su = 4'd0;
                set_st = (secTens == 4'd5) ? 4'd0 : secTens + 4'd1;
            end else begin
                set_su = secUnits + 4'd1;
            end
        end
        if (min_p) begin
            if (minUnits == 4'd9) begin
                set_mu = 4'd0;
                set_mt = (minTens == 4'd5) ? 4'd0 : minTens + 4'd1;
            end else begin
                set_mu = minUnits + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= '0;
            seg_q    <= 1'b0;
            min_q    <= 1'b0;
            seg_p    <= 1'b0;
            min_p    <= 1'b0;
            secUnits <= 4'd0;
            secTens  <= 4'd0;
            minUnits <= 4'd0;
            minTens  <= 4'd0;
            tick     <= 1'b0;
            timeUp   <= 1'b0;
        end else begin
            // Edge trackers always follow the inputs. Edges seen during a clear
            // or while running are dropped so they cannot act a cycle later.
            seg_q <= segDemand;
            min_q <= minDemand;
            seg_p <= segDemand & ~seg_q & ~resetTimer & ~enableCounter;
            min_p <= minDemand & ~min_q & ~resetTimer & ~enableCounter;

            if (resetTimer) begin
                div      <= '0;
                secUnits <= 4'd0;
                secTens  <= 4'd0;
                minUnits <= 4'd0;
                minTens  <= 4'd0;
                tick     <= 1'b0;
                timeUp   <= 1'b0;
            end else if (enableCounter) begin
                tick <= wrap;
                if (wrap) begin
                    div <= '0;
                    if (forward) begin
                        secUnits <= up_su;
                        secTens  <= up_st;
                        minUnits <= up_mu;
                        minTens  <= up_mt;
                        timeUp   <= 1'b0;
                    end else if (is_zero) begin
                        // Saturated at 00:00: count holds, flag (re)asserts.
                        timeUp <= 1'b1;
                    end else begin
                        secUnits <= dn_su;
                        secTens  <= dn_st;
                        minUnits <= dn_mu;
                        minTens  <= dn_mt;
                        if (dn_zero) begin
                            timeUp <= 1'b1;
                        end
                    end
                end else begin
                    div <= div + 1'b1;
                end
            end else begin
                // Stopped: prescaler holds so a partial second is kept.
                tick <= 1'b0;
                if (seg_p || min_p) begin
                    secUnits <= set_su;
                    secTens  <= set_st;
                    minUnits <= set_mu;
                    minTens  <= set_mt;
                    if (set_nz) begin
                        timeUp <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enableCounter = 1'b0;
    logic       forward = 1'b0;
    logic       resetTimer = 1'b0;
    logic       segDemand = 1'b0;
    logic       minDemand = 1'b0;
    logic [3:0] secUnits, secTens, minUnits, minTens;
    logic       tick, timeUp;

    timer_counter #(.TICK_DIV(4), .DIV_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enableCounter (enableCounter),
        .forward       (forward),
        .resetTimer    (resetTimer),
        .segDemand     (segDemand),
        .minDemand     (minDemand),
        .secUnits      (secUnits),
        .secTens       (secTens),
        .minUnits      (minUnits),
        .minTens       (minTens),
        .tick          (tick),
        .timeUp        (timeUp)
    );

    always #5 clk = ~clk;

    // Expected-response scoreboard. Tick entries are consumed by the monitor at
    // the negedge after they are pushed and demand tick=1; probe entries demand
    // tick=0 and a snapshot of digits/timeUp.
    typedef struct packed {
        logic        is_tick;
        logic [15:0] d;
        logic        tu;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    logic  probe = 1'b0;
    int    checks = 0;
    int    errors = 0;

    wire [15:0] digits = {minTens, minUnits, secTens, secUnits};

    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (exp_q.size() > 0 && exp_q[0].is_tick) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (tick !== 1'b1 || digits !== e.d || timeUp !== e.tu) begin
                errors++;
                $display("FAIL %s: got tick=%b %h tu=%b, want tick=1 %h tu=%b",
                         n, tick, digits, timeUp, e.d, e.tu);
            end
        end else if (tick === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tick: got tick=1 at %h, want tick=0", digits);
        end
        if (probe) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL probe_without_expectation: got empty queue, want entry");
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (tick !== 1'b0 || digits !== e.d || timeUp !== e.tu) begin
                    errors++;
                    $display("FAIL %s: got tick=%b %h tu=%b, want tick=0 %h tu=%b",
                             n, tick, digits, timeUp, e.d, e.tu);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string name, input logic [15:0] d, input logic tu);
        exp_q.push_back('{is_tick: 1'b0, d: d, tu: tu});
        name_q.push_back(name);
        probe = 1'b1;
    endtask

    task automatic tick_step(input string name, input logic [15:0] d, input logic tu);
        step();
        exp_q.push_back('{is_tick: 1'b1, d: d, tu: tu});
        name_q.push_back(name);
    endtask

    // Demand levels are set by the caller; edge 1 captures, edge 2 updates.
    task automatic pulse();
        step();
        segDemand = 1'b0;
        minDemand = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        idle(2);
        chk("reset_state", 16'h0000, 1'b0);
        rst_n = 1'b1;
        step();

        // Up-count wrap from 59:58
        for (int i = 0; i < 59; i++) begin
            segDemand = (i < 58);
            minDemand = 1'b1;
            pulse();
        end
        chk("set_5958", 16'h5958, 1'b0);
        enableCounter = 1'b1;
        forward = 1'b1;
        idle(3);
        tick_step("up_5959", 16'h5959, 1'b0);
        idle(3);
        tick_step("up_wrap", 16'h0000, 1'b0);
        enableCounter = 1'b0;

        // Down-count to zero and saturation
        repeat (2) begin
            segDemand = 1'b1;
            pulse();
        end
        chk("set_0002", 16'h0002, 1'b0);
        forward = 1'b0;
        enableCounter = 1'b1;
        idle(3);
        tick_step("dn_0001", 16'h0001, 1'b0);
        idle(3);
        tick_step("dn_0000", 16'h0000, 1'b1);
        idle(3);
        tick_step("dn_sat", 16'h0000, 1'b1);
        enableCounter = 1'b0;

        // Set mode
        repeat (59) begin
            segDemand = 1'b1;
            pulse();
        end
        chk("set_0059_clr_tu", 16'h0059, 1'b0);
        segDemand = 1'b1;
        pulse();
        chk("seg_wrap_no_carry", 16'h0000, 1'b0);
        repeat (3) begin
            minDemand = 1'b1;
            pulse();
        end
        chk("min_x3", 16'h0300, 1'b0);
        segDemand = 1'b1;
        step();
        chk("set_lat_edge1", 16'h0300, 1'b0);
        step();
        chk("set_lat_edge2", 16'h0301, 1'b0);
        idle(8);
        segDemand = 1'b0;
        step();
        chk("held_one_inc", 16'h0301, 1'b0);

        // Demands while running are ignored; stop on the would-wrap cycle
        forward = 1'b1;
        enableCounter = 1'b1;
        segDemand = 1'b1;
        minDemand = 1'b1;
        step();
        segDemand = 1'b0;
        minDemand = 1'b0;
        idle(2);
        enableCounter = 1'b0;
        chk("run_ignores_demand", 16'h0301, 1'b0);
        idle(20);
        chk("frozen_stopped", 16'h0301, 1'b0);
        enableCounter = 1'b1;
        tick_step("resume_one_cycle", 16'h0302, 1'b0);
        enableCounter = 1'b0;

        // resetTimer coincident with tick at 12:34
        for (int i = 0; i < 32; i++) begin
            segDemand = 1'b1;
            minDemand = (i < 9);
            pulse();
        end
        chk("set_1234", 16'h1234, 1'b0);
        enableCounter = 1'b1;
        idle(3);
        resetTimer = 1'b1;
        step();
        resetTimer = 1'b0;
        chk("clear_beats_tick", 16'h0000, 1'b0);
        idle(3);
        tick_step("after_clear", 16'h0001, 1'b0);
        forward = 1'b0;
        idle(3);
        tick_step("dn_again", 16'h0000, 1'b1);
        resetTimer = 1'b1;
        step();
        resetTimer = 1'b0;
        chk("clear_drops_tu", 16'h0000, 1'b0);
        forward = 1'b1;
        idle(3);
        tick_step("pre_async", 16'h0001, 1'b0);

        // Asynchronous reset mid-count, released mid-cycle
        step();
        #2 rst_n = 1'b0;
        chk("async_reset", 16'h0000, 1'b0);
        step();
        #3 rst_n = 1'b1;
        idle(3);
        tick_step("post_async", 16'h0001, 1'b0);

        // Direction flip between ticks
        enableCounter = 1'b0;
        resetTimer = 1'b1;
        step();
        resetTimer = 1'b0;
        for (int i = 0; i < 59; i++) begin
            segDemand = 1'b1;
            minDemand = (i < 9);
            pulse();
        end
        chk("set_0959", 16'h0959, 1'b0);
        enableCounter = 1'b1;
        forward = 1'b1;
        idle(3);
        tick_step("flip_up", 16'h1000, 1'b0);
        step();
        forward = 1'b0;
        idle(2);
        tick_step("flip_down", 16'h0959, 1'b0);
        enableCounter = 1'b0;
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
